apb_regbank: RTL

//  Parametrised APB4 slave register bank: NUM_CTRL read/write control words, NUM_STAT read-only

---
 rtl/apb_regbank.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/apb_regbank.sv
// apb_regbank: APB4 slave register bank with control words, status words,
// an ID word and a masked change-detect interrupt.
module apb_regbank #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_CTRL    = 4,
  parameter int                NUM_STAT    = 4,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] CTRL_RESET  = '0,
  parameter logic [31:0]       ID_VALUE    = 32'h00216948
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W/8-1:0]        pstrb,
  input  logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [NUM_STAT*DATA_W-1:0] status_in,
  output logic [NUM_CTRL*DATA_W-1:0] control_out,
  output logic                       irq
);

  localparam int          SB      = DATA_W / 8;
  localparam logic [31:0] STAT_LO = 32'd4;
  localparam logic [31:0] CTRL_LO = 32'(4 + NUM_STAT);
  localparam logic [31:0] MAP_END = 32'(4 + NUM_STAT + NUM_CTRL);
  localparam logic [2:0]  WS      = 3'(WAIT_STATES);

  logic [31:0] wi;
  logic [31:0] sidx;
  logic [31:0] cidx;
  logic        unused_lsb;

  assign wi         = 32'(paddr[ADDR_W-1:2]);
  assign sidx       = wi - STAT_LO;
  assign cidx       = wi - CTRL_LO;
  assign unused_lsb = ^paddr[1:0];

  logic is_id, is_ist, is_msk, is_rsv;
  logic is_stat, is_ctrl, is_bad;

  assign is_id   = (wi == 32'd0);
  assign is_ist  = (wi == 32'd1);
  assign is_msk  = (wi == 32'd2);
  assign is_rsv  = (wi == 32'd3);
  assign is_stat = (wi >= STAT_LO) && (wi < CTRL_LO);
  assign is_ctrl = (wi >= CTRL_LO) && (wi < MAP_END);
  assign is_bad  = (wi >= MAP_END);

  logic [2:0] cnt;
  logic       access;
  logic       commit;
  logic       err;
  logic       wr_ok;
  logic       rd_ok;

  assign access  = psel & penable;
  assign pready  = reset ? 1'b0
                 : (access ? (enable & (cnt == WS)) : 1'b1);
  assign commit  = access & pready;
  assign err     = commit & (is_rsv | is_bad
                 | (pwrite & (is_id | is_stat)));
  assign pslverr = err;
  assign wr_ok   = commit & pwrite & ~err;
  assign rd_ok   = commit & ~pwrite & ~err;

  // Wait-state counter: counts stalled access cycles, frozen when disabled.
  always_ff @(posedge pclk) begin
    if (reset) begin
      cnt <= '0;
    end else if (enable) begin
      if (!access || commit) cnt <= '0;
      else if (cnt != WS)    cnt <= cnt + 3'd1;
    end
  end

  logic [DATA_W-1:0] bmask;
  logic [DATA_W-1:0] wmask;

  // Expand byte strobes into a per-bit write mask.
  always_comb begin
    bmask = '0;
    for (int b = 0; b < SB; b++) begin
      bmask[b*8 +: 8] = {8{pstrb[b]}};
    end
  end

  assign wmask = pwdata & bmask;

  logic [DATA_W-1:0]   st   [NUM_STAT];
  logic [DATA_W-1:0]   prev [NUM_STAT];
  logic [DATA_W-1:0]   ctrl [NUM_CTRL];
  logic [NUM_STAT-1:0] chg;
  logic [NUM_STAT-1:0] ist;
  logic [NUM_STAT-1:0] msk;
  logic [NUM_STAT-1:0] ist_clr;

  for (genvar g = 0; g < NUM_STAT; g++) begin : g_st
    assign st[g] = status_in[g*DATA_W +: DATA_W];
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_co
    assign control_out[g*DATA_W +: DATA_W] = ctrl[g];
  end

  // Per-word change flags against last cycle's status snapshot.
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_STAT; i++) begin
      chg[i] = (st[i] != prev[i]);
    end
  end

  assign ist_clr = (wr_ok & is_ist) ? wmask[NUM_STAT-1:0] : '0;

  // Status snapshot; reload on reset so no change is seen right after.
  always_ff @(posedge pclk) begin
    if (reset || enable) begin
      for (int i = 0; i < NUM_STAT; i++) prev[i] <= st[i];
    end
  end

  // Interrupt status (sticky, W1C, set beats clear) and mask.
  always_ff @(posedge pclk) begin
    if (reset) begin
      ist <= '0;
      msk <= '0;
    end else if (enable) begin
      ist <= (ist & ~ist_clr) | chg;
      if (wr_ok && is_msk) begin
        msk <= (msk & ~bmask[NUM_STAT-1:0])
             | wmask[NUM_STAT-1:0];
      end
    end
  end

  // Control words, byte-lane writes on the commit edge.
  always_ff @(posedge pclk) begin
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (reset) begin
        ctrl[i] <= CTRL_RESET;
      end else if (enable && wr_ok && is_ctrl
                   && cidx == 32'(i)) begin
        ctrl[i] <= (ctrl[i] & ~bmask) | wmask;
      end
    end
  end

  logic [DATA_W-1:0] stat_rd;
  logic [DATA_W-1:0] ctrl_rd;
  logic [DATA_W-1:0] rsel;

  // Read mux; only driven out during a read commit.
  always_comb begin
    stat_rd = '0;
    ctrl_rd = '0;
    rsel    = '0;
    for (int i = 0; i < NUM_STAT; i++) begin
      if (sidx == 32'(i)) stat_rd = st[i];
    end
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (cidx == 32'(i)) ctrl_rd = ctrl[i];
    end
    unique case (1'b1)
      is_id:   rsel = ID_VALUE[DATA_W-1:0];
      is_ist:  rsel = DATA_W'(ist);
      is_msk:  rsel = DATA_W'(msk);
      is_stat: rsel = stat_rd;
      is_ctrl: rsel = ctrl_rd;
      default: rsel = '0;
    endcase
  end

  assign prdata = rd_ok ? rsel : '0;
  assign irq    = |(ist & msk);

endmodule
